// File: rtl/mux_example_pkg.sv
// Shared definitions for the mux_example selector: select width, input count
// and the symbolic select codes.
package mux_example_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_IN = 4;

    typedef enum logic [SEL_W-1:0] {
        SEL_I0 = 2'd0,
        SEL_I1 = 2'd1,
        SEL_I2 = 2'd2,
        SEL_I3 = 2'd3
    } sel_e;

endpackage

// File: rtl/mux_example_if.sv
// Bundle of the mux_example data/select and telemetry signals; the master side
// drives select, data and enable, the slave side produces the results.
interface mux_example_if #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
);
    import mux_example_pkg::*;

    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] i0;
    logic [DATA_W-1:0] i1;
    logic [DATA_W-1:0] i2;
    logic [DATA_W-1:0] i3;
    logic [DATA_W-1:0] y;
    logic              en;
    logic [DATA_W-1:0] y_q;
    logic [SEL_W-1:0]  sel_q;
    logic              sel_chg;
    logic [CNT_W-1:0]  sw_cnt;

    modport master (
        output sel, i0, i1, i2, i3, en,
        input  y, y_q, sel_q, sel_chg, sw_cnt
    );

    modport slave (
        input  sel, i0, i1, i2, i3, en,
        output y, y_q, sel_q, sel_chg, sw_cnt
    );

endinterface

// File: rtl/mux_example_mux4.sv
// Combinational 4:1 selector; a select that is not a clean binary code
// (X/Z in simulation) yields all zeros.
module mux4_comb
    import mux_example_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux_example.sv
// Four-input selector with a combinational result, an enable-gated registered
// copy, and select-change telemetry (pulse plus saturating counter).
module mux_example
    import mux_example_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    output logic [DATA_W-1:0] y,
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [DATA_W-1:0] y_q,
    output logic [SEL_W-1:0]  sel_q,
    output logic              sel_chg,
    output logic [CNT_W-1:0]  sw_cnt
);

    logic sel_diff;
    logic cnt_max;

    mux4_comb #(
        .DATA_W (DATA_W)
    ) u_mux4 (
        .sel (sel),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .y   (y)
    );

    // Change is judged against the previously sampled select, which is 0 out of reset.
    assign sel_diff = (sel != sel_q);
    assign cnt_max  = (sw_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            sel_q   <= '0;
            sel_chg <= 1'b0;
            sw_cnt  <= '0;
        end else begin
            sel_q   <= sel;
            sel_chg <= sel_diff;
            if (en) begin
                y_q <= y;
            end
            if (sel_diff && !cnt_max) begin
                sw_cnt <= sw_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_example.sv
// Directed self-checking bench for mux_example: combinational select, registered
// copy, change pulse/counter, saturation with a narrow counter, and async reset.
module tb_mux_example;
    import mux_example_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux_example_if #(.DATA_W(1), .CNT_W(8)) bus ();
    mux_example_if #(.DATA_W(1), .CNT_W(2)) bus_s ();

    mux_example #(.DATA_W(1), .CNT_W(8)) dut (
        .sel     (bus.sel),
        .i0      (bus.i0),
        .i1      (bus.i1),
        .i2      (bus.i2),
        .i3      (bus.i3),
        .y       (bus.y),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .y_q     (bus.y_q),
        .sel_q   (bus.sel_q),
        .sel_chg (bus.sel_chg),
        .sw_cnt  (bus.sw_cnt)
    );

    mux_example #(.DATA_W(1), .CNT_W(2)) dut_s (
        .sel     (bus_s.sel),
        .i0      (bus_s.i0),
        .i1      (bus_s.i1),
        .i2      (bus_s.i2),
        .i3      (bus_s.i3),
        .y       (bus_s.y),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus_s.en),
        .y_q     (bus_s.y_q),
        .sel_q   (bus_s.sel_q),
        .sel_chg (bus_s.sel_chg),
        .sw_cnt  (bus_s.sw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive select/enable just after an edge, then step to 1 unit after the next edge.
    task automatic applyStimulus(input logic [1:0] s, input logic e);
        bus.sel = s;
        bus.en  = e;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] seq_sel [5];
    logic       seq_chg [5];
    logic [7:0] seq_cnt [5];
    logic       comb_exp [4];
    logic       tog_chg [6];
    logic [1:0] tog_cnt [6];

    initial begin
        errors = 0;
        checks = 0;
        seq_sel  = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
        seq_chg  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        seq_cnt  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
        comb_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        tog_chg  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tog_cnt  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        bus.sel = 2'd0; bus.en = 1'b0;
        bus.i0 = 1'b0; bus.i1 = 1'b0; bus.i2 = 1'b0; bus.i3 = 1'b0;
        bus_s.sel = 2'd0; bus_s.en = 1'b0;
        bus_s.i0 = 1'b0; bus_s.i1 = 1'b0; bus_s.i2 = 1'b0; bus_s.i3 = 1'b0;
        #2;

        checkOutput("rst_y_q", 32'(bus.y_q), 32'd0);
        checkOutput("rst_sel_q", 32'(bus.sel_q), 32'd0);
        checkOutput("rst_sel_chg", 32'(bus.sel_chg), 32'd0);
        checkOutput("rst_sw_cnt", 32'(bus.sw_cnt), 32'd0);

        // {i3,i2,i1,i0} = 4'h5; y follows select even while reset is held
        {bus.i3, bus.i2, bus.i1, bus.i0} = 4'h5;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            checkOutput($sformatf("comb_sel%0d", s), 32'(bus.y), 32'(comb_exp[s]));
            #4;
        end
        checkOutput("rst_hold_cnt", 32'(bus.sw_cnt), 32'd0);

        bus.sel = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            applyStimulus(seq_sel[k], 1'b0);
            checkOutput($sformatf("seq%0d_sel_q", k), 32'(bus.sel_q), 32'(seq_sel[k]));
            checkOutput($sformatf("seq%0d_sel_chg", k), 32'(bus.sel_chg), 32'(seq_chg[k]));
            checkOutput($sformatf("seq%0d_sw_cnt", k), 32'(bus.sw_cnt), 32'(seq_cnt[k]));
        end
        checkOutput("seq_y_q_idle", 32'(bus.y_q), 32'd0);

        // sel change and enable on the same edge: loads i2 = 1
        applyStimulus(2'd2, 1'b1);
        checkOutput("en_y_q", 32'(bus.y_q), 32'd1);
        checkOutput("en_sel_chg", 32'(bus.sel_chg), 32'd1);
        checkOutput("en_sw_cnt", 32'(bus.sw_cnt), 32'd3);
        applyStimulus(2'd3, 1'b0);
        checkOutput("hold_y_q", 32'(bus.y_q), 32'd1);
        checkOutput("hold_y", 32'(bus.y), 32'd0);
        checkOutput("hold_sw_cnt", 32'(bus.sw_cnt), 32'd4);

        // Narrow counter saturates at 3 while the pulse keeps firing
        for (int k = 0; k < 6; k++) begin
            bus_s.sel = (k % 2 == 0) ? 2'd1 : 2'd0;
            @(posedge clk);
            #1;
            checkOutput($sformatf("sat%0d_sw_cnt", k), 32'(bus_s.sw_cnt), 32'(tog_cnt[k]));
            checkOutput($sformatf("sat%0d_sel_chg", k), 32'(bus_s.sel_chg), 32'(tog_chg[k]));
        end

        // Async reset between edges clears state immediately
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_y_q", 32'(bus.y_q), 32'd0);
        checkOutput("arst_sel_q", 32'(bus.sel_q), 32'd0);
        checkOutput("arst_sel_chg", 32'(bus_s.sel_chg), 32'd0);
        checkOutput("arst_sw_cnt", 32'(bus.sw_cnt), 32'd0);
        checkOutput("arst_sw_cnt_s", 32'(bus_s.sw_cnt), 32'd0);
        bus.sel = 2'd2;
        #1;
        checkOutput("arst_y_sel2", 32'(bus.y), 32'd1);
        bus.sel = 2'd1;
        #1;
        checkOutput("arst_y_sel1", 32'(bus.y), 32'd0);
        bus.i1 = 1'b1;
        #1;
        checkOutput("arst_y_i1", 32'(bus.y), 32'd1);

        // Non-binary select drives zeros
        bus.i0 = 1'b0; bus.i1 = 1'b0; bus.i2 = 1'b0; bus.i3 = 1'b0;
        bus.sel = 2'bxx;
        #1;
        checkOutput("selx_y", 32'(bus.y), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
